// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: RV32I funct3 encodings,
// the clear/run state type and the illegal-funct3 check.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Unsigned variants exist only for loads, so a store with BU/HU is illegal.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
        logic bad;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = is_store;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane select and sign/zero extension for one 32-bit memory word.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed byte/halfword, then extend according to funct3.
    always_comb begin
        lane_b = 8'h00;
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (off)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        case (funct3)
            F3_B:    data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   data = {24'h000000, lane_b};
            F3_H:    data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   data = {16'h0000, lane_h};
            F3_W:    data = word;
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_memory_bytelane.sv
// MEM-stage data memory with RV32I byte/halfword/word access, fault
// detection and a post-reset clear engine that zeroes one word per cycle.
// Optional build macro DMEM_DEBUG_TAP_EN exposes word 0 on port DM0.
//
// state | meaning
// CLEAR | zeroing mem[clr_ptr]; accesses ignored, outputs held quiet
// RUN   | normal load/store service, Ready high
module data_memory_bytelane
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        MisalignM,
    output logic        ErrSticky
`ifdef DMEM_DEBUG_TAP_EN
    ,
    output logic [31:0] DM0
`endif
);

    localparam int AW = $clog2(DEPTH);

    state_t        state, state_nxt;
    logic [AW-1:0] clr_ptr, clr_ptr_nxt;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] word_idx;
    logic [1:0]    off;
    logic          run;
    logic          out_of_range;
    logic          size_mis;
    logic          load_fault;
    logic          store_fault;
    logic          do_store;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   load_data;

    assign word_idx     = ALUResultM[AW+1:2];
    assign off          = ALUResultM[1:0];
    assign run          = (state == RUN);
    assign out_of_range = |ALUResultM[31:AW+2];
    assign Ready        = run;

    // Natural-alignment check for the access size.
    always_comb begin
        case (funct3M)
            F3_H, F3_HU: size_mis = off[0];
            F3_W:        size_mis = |off;
            default:     size_mis = 1'b0;
        endcase
    end

    assign load_fault  = out_of_range | size_mis | f3_illegal(funct3M, 1'b0);
    assign store_fault = out_of_range | size_mis | f3_illegal(funct3M, 1'b1);
    assign MisalignM   = run & ((MemWriteM & store_fault) | (MemReadM & load_fault));
    assign do_store    = run & MemWriteM & ~store_fault;

    // Byte enables and lane-replicated write data; illegal sizes never reach do_store.
    always_comb begin
        be    = 4'b0000;
        wdata = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                be    = 4'b0001 << off;
                wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{WriteDataM[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // State register, clear pointer and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            ErrSticky <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
            if (run) begin
                ErrSticky <= ErrSticky | MisalignM;
            end
        end
    end

    // Next-state: walk the clear pointer to the last word, then go to RUN.
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        case (state)
            CLEAR: begin
                clr_ptr_nxt = clr_ptr + AW'(1);
                if (clr_ptr == AW'(DEPTH - 1)) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Memory array: clear writes during CLEAR, byte-lane stores during RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (!run) begin
                mem[clr_ptr] <= 32'h0000_0000;
            end else if (do_store) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    dmem_load_align u_load_align (
        .word   (mem[word_idx]),
        .off    (off),
        .funct3 (funct3M),
        .data   (load_data)
    );

    assign ReadData = (run && !load_fault) ? load_data : 32'h0000_0000;

`ifdef DMEM_DEBUG_TAP_EN
    assign DM0 = mem[0];
`endif

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Randomised + directed bench for data_memory_bytelane (DEPTH=16) against a
// byte-addressed behavioural model.
module tb_data_memory_bytelane;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemWriteM = 1'b0;
    logic        MemReadM = 1'b0;
    logic [2:0]  funct3M = 3'b010;
    logic [31:0] ALUResultM = 32'h0;
    logic [31:0] WriteDataM = 32'h0;
    logic [31:0] ReadData;
    logic        Ready;
    logic        MisalignM;
    logic        ErrSticky;
`ifdef DMEM_DEBUG_TAP_EN
    logic [31:0] DM0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    data_memory_bytelane #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadData   (ReadData),
        .Ready      (Ready),
        .MisalignM  (MisalignM),
        .ErrSticky  (ErrSticky)
`ifdef DMEM_DEBUG_TAP_EN
        ,
        .DM0        (DM0)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_ready = 1'b0;
    bit          m_err   = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_mem [DEPTH];

    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit m_fault(input logic [31:0] addr, input logic [2:0] f3, input bit st);
        int sz;
        sz = acc_size(f3);
        if (sz == 0) return 1'b1;
        if (st && f3[2]) return 1'b1;
        if (addr >= 32'(4 * DEPTH)) return 1'b1;
        if ((addr % sz) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_rdata();
        logic [31:0] w, v;
        if (!m_ready || m_fault(ALUResultM, funct3M, 1'b0)) return 32'h0;
        w = m_mem[ALUResultM / 4];
        v = w >> (8 * (ALUResultM % 4));
        case (funct3M)
            3'b000:  return (v[7]  ? 32'hFFFF_FF00 : 32'h0) | (v & 32'hFF);
            3'b100:  return v & 32'hFF;
            3'b001:  return (v[15] ? 32'hFFFF_0000 : 32'h0) | (v & 32'hFFFF);
            3'b101:  return v & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic bit m_mis();
        if (!m_ready) return 1'b0;
        return (MemWriteM && m_fault(ALUResultM, funct3M, 1'b1)) ||
               (MemReadM  && m_fault(ALUResultM, funct3M, 1'b0));
    endfunction

    // Model update on each rising edge, from the inputs presented in that cycle.
    always @(posedge clk) begin
        if (!rst) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            m_err   = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == DEPTH) m_ready = 1'b1;
        end else begin
            if (m_mis()) m_err = 1'b1;
            if (MemWriteM && !m_fault(ALUResultM, funct3M, 1'b1)) begin
                for (int i = 0; i < acc_size(funct3M); i++) begin
                    int b;
                    logic [31:0] w;
                    b = int'(ALUResultM) + i;
                    w = m_mem[b / 4];
                    w = w & ~(32'hFF << (8 * (b % 4)));
                    w = w | (((WriteDataM >> (8 * i)) & 32'hFF) << (8 * (b % 4)));
                    m_mem[b / 4] = w;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",     32'(Ready),     32'(m_ready));
            check("readdata",  ReadData,       m_rdata());
            check("misalign",  32'(MisalignM), 32'(m_mis()));
            check("errsticky", 32'(ErrSticky), 32'(m_err));
`ifdef DMEM_DEBUG_TAP_EN
            if (m_ready) check("dm0", DM0, m_mem[0]);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_acc(input bit wr, input bit rd, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data);
        MemWriteM  = wr;
        MemReadM   = rd;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = data;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        set_acc(1'b1, 1'b0, f3, addr, data);
        tick();
        set_acc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    endtask

    task automatic load_chk(input string name, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] exp);
        set_acc(1'b0, 1'b1, f3, addr, 32'h0);
        @(negedge clk);
        check(name, ReadData, exp);
        check({name, "_model"}, m_rdata(), exp);
        tick();
        set_acc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    endtask

    // Counts edges after release until Ready; optionally drives a store at edge 5.
    task automatic count_ready(input string name, input bit clr_store, output int cycles);
        cycles = 0;
        while (!Ready && cycles < 100) begin
            if (clr_store && cycles == 4) set_acc(1'b1, 1'b0, 3'b010, 32'h4, 32'hFFFF_FFFF);
            tick();
            cycles++;
            if (clr_store && cycles == 5) set_acc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        end
        if (cycles >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: Ready never rose within 100 cycles", name);
        end
    endtask

    initial begin
        int cyc;

        // Reset held 3 cycles, Ready must rise on the 16th edge after release.
        rst = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        count_ready("reset_latency", 1'b1, cyc);
        check("reset_latency", 32'(cyc), 32'd16);
        load_chk("clear_store_ignored", 3'b010, 32'h4, 32'h0);

        // Reset pulsed mid-CLEAR restarts the full sequence.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (8) tick();
        check("midclear_not_ready", 32'(Ready), 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        count_ready("midclear_latency", 1'b0, cyc);
        check("midclear_latency", 32'(cyc), 32'd16);

        for (int i = 0; i < DEPTH; i++) load_chk("zero_word", 3'b010, 32'(4 * i), 32'h0);

        // Loads with sign/zero extension.
        store(3'b010, 32'h8, 32'hDEAD_BEEF);
        load_chk("lb_8",   3'b000, 32'h8, 32'hFFFF_FFEF);
        load_chk("lbu_b",  3'b100, 32'hB, 32'h0000_00DE);
        load_chk("lh_a",   3'b001, 32'hA, 32'hFFFF_DEAD);
        load_chk("lhu_8",  3'b101, 32'h8, 32'h0000_BEEF);

        // Partial stores.
        store(3'b000, 32'h9, 32'h0000_0012);
        load_chk("sb_merge", 3'b010, 32'h8, 32'hDEAD_12EF);
        store(3'b001, 32'hA, 32'h0000_5566);
        load_chk("sh_merge", 3'b010, 32'h8, 32'h5566_12EF);

        // Same-cycle load sees old data, next cycle sees the new word.
        set_acc(1'b1, 1'b1, 3'b010, 32'h8, 32'h0BAD_F00D);
        @(negedge clk);
        check("rw_same_cycle_old", ReadData, 32'h5566_12EF);
        tick();
        set_acc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        load_chk("rw_next_cycle_new", 3'b010, 32'h8, 32'h0BAD_F00D);

        // Faulting stores: misaligned and out of range.
        check("err_clean", 32'(ErrSticky), 32'd0);
        set_acc(1'b1, 1'b0, 3'b010, 32'h6, 32'h1111_1111);
        @(negedge clk);
        check("sw_mis_flag", 32'(MisalignM), 32'd1);
        tick();
        set_acc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        @(negedge clk);
        check("sw_mis_sticky", 32'(ErrSticky), 32'd1);
        load_chk("sw_mis_w1", 3'b010, 32'h4, 32'h0);
        set_acc(1'b1, 1'b0, 3'b010, 32'h40, 32'h2222_2222);
        @(negedge clk);
        check("sw_oor_flag", 32'(MisalignM), 32'd1);
        tick();
        set_acc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        load_chk("sw_oor_w0", 3'b010, 32'h0, 32'h0);
        check("sticky_holds", 32'(ErrSticky), 32'd1);

`ifdef DMEM_DEBUG_TAP_EN
        store(3'b010, 32'h0, 32'h0000_CAFE);
        @(negedge clk);
        check("dm0_tap", DM0, 32'h0000_CAFE);
        tick();
`endif

        // Randomised traffic with rare reset pulses.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 4 * DEPTH - 1));
            set_acc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), a, $urandom);
            rst = ($urandom_range(0, 249) != 0);
            tick();
        end
        set_acc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        rst = 1'b1;
        repeat (DEPTH + 2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
